// File: rtl/calc_op_sequencer.sv
// Round-robin sequencer for a shared add/sub/mul/div unit; one op in flight, result tagged with requester id.
// Latency 1 (add/sub/div-by-0) or WIDTH+1 (mul/div); result held in DONE until res_ready, no accepts meanwhile.
module calc_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_op,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_value,
  output logic               res_flag
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flag_q, flag_d;

  logic               grant;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [1:0]         sel_op;
  logic [WIDTH:0]     sum, diff, hi_sum, div_shift, div_trial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= OP_ADD;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    grant  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
    sum    = {1'b0, sel_a} + {1'b0, sel_b};
    diff   = {1'b0, sel_a} - {1'b0, sel_b};

    // Mul: acc = {partial hi, multiplier lo}, shifted right each step with the add carry.
    hi_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Div: acc = {remainder, dividend/quotient}, restoring step on the shifted remainder.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};

    unique case (state_q)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          id_d         = grant;
          last_grant_d = grant;
          op_d         = sel_op;
          flag_d       = 1'b0;
          state_d      = DONE;
          unique case (sel_op)
            OP_ADD: begin
              acc_d  = {{(WIDTH-1){1'b0}}, sum};
              flag_d = sum[WIDTH];
            end
            OP_SUB: begin
              acc_d  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              flag_d = diff[WIDTH];
            end
            OP_MUL: begin
              opnd_d  = sel_a;
              acc_d   = {{WIDTH{1'b0}}, sel_b};
              cnt_d   = CW'(WIDTH);
              state_d = ITER;
            end
            default: begin
              if (sel_b == '0) begin
                acc_d  = {sel_a, {WIDTH{1'b1}}};
                flag_d = 1'b1;
              end else begin
                opnd_d  = sel_b;
                acc_d   = {{WIDTH{1'b0}}, sel_a};
                cnt_d   = CW'(WIDTH);
                state_d = ITER;
              end
            end
          endcase
        end
      end
      ITER: begin
        if (op_q == OP_MUL) begin
          acc_d = {hi_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
          acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_valid = (state_q == DONE);
  assign res_id    = res_valid & id_q;
  assign res_flag  = res_valid & flag_q;
  assign res_value = res_valid ? acc_q : '0;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: arithmetic/timing model checked every cycle, plus directed literal checks.
module tb_calc_op_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic         res_valid, res_ready = 1'b1, res_id, res_flag;
  logic [2*W-1:0] res_value;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_value(res_value), .res_flag(res_flag)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {flag, value}.
  function automatic logic [16:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, s;
    logic [15:0] v;
    logic f;
    ia = a; ib = b;
    case (op)
      2'd0: begin s = ia + ib; v = 16'(s); f = (s > 255); end
      2'd1: begin v = 16'((ia - ib + 256) % 256); f = (ia < ib); end
      2'd2: begin v = 16'(ia * ib); f = 1'b0; end
      default: begin
        if (ib == 0) begin v = {a, 8'hFF}; f = 1'b1; end
        else begin v = {8'(ia % ib), 8'(ia / ib)}; f = 1'b0; end
      end
    endcase
    return {f, v};
  endfunction

  // Model state
  int cyc_n = 0, rise_cyc = 0, acc_cyc = 0, last_g = 1;
  bit busy = 0;
  logic [16:0] exp_r;
  logic exp_id;
  int res_cnt = 0, got_lat = 0, got_cyc = 0;
  logic [15:0] got_val;
  logic got_id, got_flag;
  int grants[$];
  int acc_cycles[$];
  bit prev_stall = 0;
  logic [15:0] prev_val;
  logic prev_id, prev_flag;
  bit e0, e1;

  always @(negedge clk) begin
    cyc_n++;
    if (reset) begin
      chk("rst_valid", res_valid, 0);
      chk("rst_value", res_value, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_id_flag", {res_id, res_flag}, 0);
      busy = 0; last_g = 1; prev_stall = 0;
    end else begin
      e0 = !busy && req0_valid && (!req1_valid || last_g == 1);
      e1 = !busy && req1_valid && (!req0_valid || last_g == 0);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("res_valid", res_valid, busy && cyc_n >= rise_cyc);
      if (prev_stall) begin
        chk("stall_value", res_value, prev_val);
        chk("stall_id_flag", {res_id, res_flag}, {prev_id, prev_flag});
      end
      if (res_valid && res_ready && busy && cyc_n >= rise_cyc) begin
        chk("res_value", res_value, exp_r[15:0]);
        chk("res_id", res_id, exp_id);
        chk("res_flag", res_flag, exp_r[16]);
        got_val = res_value; got_id = res_id; got_flag = res_flag;
        got_lat = cyc_n - acc_cyc; got_cyc = cyc_n;
        res_cnt++;
        busy = 0;
      end
      prev_stall = res_valid && !res_ready;
      prev_val = res_value; prev_id = res_id; prev_flag = res_flag;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        exp_id = !(req0_valid && req0_ready);
        exp_r = exp_id ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
        busy = 1;
        acc_cyc = cyc_n;
        rise_cyc = cyc_n + ((exp_id ? (req1_op == 2'd2 || (req1_op == 2'd3 && req1_b != 0))
                                    : (req0_op == 2'd2 || (req0_op == 2'd3 && req0_b != 0))) ? W + 1 : 1);
        last_g = exp_id;
        grants.push_back(exp_id);
        acc_cycles.push_back(cyc_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int port, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit done;
    done = 0;
    if (port == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) done = 1;
      tick();
    end
    if (port == 0) req0_valid = 0; else req1_valid = 0;
    chk("send_accepted", done, 1);
  endtask

  task automatic wait_res(input int start);
    for (int i = 0; i < 40 && res_cnt == start; i++) tick();
    chk("result_arrived", res_cnt != start, 1);
  endtask

  int start, n0;

  initial begin
    repeat (3) tick();
    chk("rst_valid_lit", res_valid, 0);
    reset = 0;
    tick();

    start = res_cnt; send(0, 2'd2, 8'd7, 8'd8); wait_res(start);
    chk("mul_val", got_val, 16'd56); chk("mul_id", got_id, 0);
    chk("mul_flag", got_flag, 0);    chk("mul_lat", got_lat, 9);

    start = res_cnt; send(1, 2'd3, 8'd200, 8'd7); wait_res(start);
    chk("div_val", got_val, 16'h041C); chk("div_id", got_id, 1);
    chk("div_flag", got_flag, 0);      chk("div_lat", got_lat, 9);
    tick();

    n0 = grants.size();
    req0_valid = 1; req0_op = 2'd0; req0_a = 8'd10; req0_b = 8'd1;
    req1_valid = 1; req1_op = 2'd0; req1_a = 8'd20; req1_b = 8'd2;
    repeat (12) tick();
    req0_valid = 0; req1_valid = 0;
    repeat (3) tick();
    chk("alt_count", grants.size() >= n0 + 4, 1);
    for (int i = 0; i < 4; i++) chk("alt_grant", grants[n0 + i], i % 2);
    for (int i = 0; i < 3; i++) chk("alt_interval", acc_cycles[n0 + i + 1] - acc_cycles[n0 + i], 2);

    start = res_cnt; send(0, 2'd3, 8'd13, 8'd0); wait_res(start);
    chk("dz_val", got_val, 16'h0DFF); chk("dz_flag", got_flag, 1); chk("dz_lat", got_lat, 1);

    start = res_cnt; send(1, 2'd1, 8'd3, 8'd5); wait_res(start);
    chk("sub_val", got_val, 16'h00FE); chk("sub_flag", got_flag, 1);
    chk("sub_id", got_id, 1);          chk("sub_lat", got_lat, 1);

    start = res_cnt; send(0, 2'd0, 8'd200, 8'd100); wait_res(start);
    chk("add_val", got_val, 16'd300); chk("add_flag", got_flag, 1);
    tick();

    // Consumer stall with a competing request pending
    res_ready = 0;
    start = res_cnt; send(0, 2'd0, 8'd1, 8'd2);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    req1_valid = 1; req1_op = 2'd2; req1_a = 8'd4; req1_b = 8'd5;
    repeat (5) tick();
    chk("stall_held", res_valid, 1);
    chk("stall_no_handoff", res_cnt, start);
    n0 = grants.size();
    res_ready = 1;
    wait_res(start);
    chk("stall_val", got_val, 16'd3);
    for (int i = 0; i < 10 && grants.size() == n0; i++) tick();
    req1_valid = 0;
    chk("resume_id", grants[$], 1);
    chk("resume_gap", acc_cycles[$] - got_cyc, 1);
    start = res_cnt; wait_res(start);
    chk("resume_val", got_val, 16'd20);

    // Reset during a multiply
    tick();
    start = res_cnt; send(0, 2'd2, 8'd5, 8'd6);
    repeat (3) tick();
    reset = 1;
    req0_valid = 1; req0_op = 2'd0; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1; req1_op = 2'd0; req1_a = 8'd2; req1_b = 8'd2;
    repeat (2) tick();
    n0 = grants.size();
    reset = 0;
    chk("rst_discard", res_cnt, start);
    for (int i = 0; i < 10 && grants.size() == n0; i++) tick();
    req0_valid = 0; req1_valid = 0;
    chk("rst_tie_grant", grants[$], 0);
    wait_res(start);
    chk("rst_next_val", got_val, 16'd2);
    chk("rst_next_id", got_id, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
